// File: rtl/mul_dispatch_pkg.sv
// Shared types and constants for the multiplier request front-end.
// MUL_DISPATCH_SIGNED_EN selects two's-complement operands and product.
package mul_dispatch_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        RESP
    } state_e;

`ifdef MUL_DISPATCH_SIGNED_EN
    localparam int SGN_W = 1;

    // -128 maps onto itself (8'h80), which the unsigned core reads as 128
    function automatic logic [OP_W-1:0] op_mag(input logic [OP_W-1:0] v);
        return v[OP_W-1] ? -v : v;
    endfunction
`else
    localparam int SGN_W = 0;
`endif

endpackage

// File: rtl/mul_dispatch_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push and pop must be pre-qualified
// by the caller against full and empty.
module mul_dispatch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty = (wptr == rptr);

endmodule

// File: rtl/mul_dispatch.sv
// Request front-end for the sequential 8x8 multiplier: FIFO, issue FSM, response hold.
// MUL_DISPATCH_SIGNED_EN: send magnitudes, re-apply sign to the product at capture.
module mul_dispatch
    import mul_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [OP_W-1:0]   req_a_i,
    input  logic [OP_W-1:0]   req_b_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic [OP_W-1:0]   mul_a_o,
    output logic [OP_W-1:0]   mul_b_o,
    output logic              mul_start_o,
    input  logic              mul_busy_i,
    input  logic [PROD_W-1:0] mul_y_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [PROD_W-1:0] resp_data_o,
    output logic [TAG_W-1:0]  resp_tag_o,
    output logic              busy_o
);

    localparam int ENT_W = 2*OP_W + TAG_W + SGN_W;

    state_e             state_q, state_d;
    logic [ENT_W-1:0]   wdata, rdata;
    logic               full, empty, push, pop, done;
    logic [TAG_W-1:0]   tag_q;

    assign push = req_valid_i && !full;
    assign pop  = (state_q == IDLE) && !empty;
    assign done = (state_q == WAIT_LO) && !mul_busy_i;

`ifdef MUL_DISPATCH_SIGNED_EN
    logic sign_q;
    assign wdata = {req_a_i[OP_W-1] ^ req_b_i[OP_W-1], req_tag_i, req_a_i, req_b_i};
`else
    assign wdata = {req_tag_i, req_a_i, req_b_i};
`endif

    mul_dispatch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .wdata  (wdata),
        .pop    (pop),
        .rdata  (rdata),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty)       state_d = ISSUE;
            ISSUE:                     state_d = WAIT_HI;
            WAIT_HI: if (mul_busy_i)   state_d = WAIT_LO;
            WAIT_LO: if (!mul_busy_i)  state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            mul_a_o      <= '0;
            mul_b_o      <= '0;
            tag_q        <= '0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_tag_o   <= '0;
`ifdef MUL_DISPATCH_SIGNED_EN
            sign_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (pop) begin
                tag_q <= rdata[2*OP_W +: TAG_W];
`ifdef MUL_DISPATCH_SIGNED_EN
                mul_a_o <= op_mag(rdata[OP_W +: OP_W]);
                mul_b_o <= op_mag(rdata[0 +: OP_W]);
                sign_q  <= rdata[ENT_W-1];
`else
                mul_a_o <= rdata[OP_W +: OP_W];
                mul_b_o <= rdata[0 +: OP_W];
`endif
            end
            if (done) begin
`ifdef MUL_DISPATCH_SIGNED_EN
                resp_data_o <= sign_q ? -mul_y_i : mul_y_i;
`else
                resp_data_o <= mul_y_i;
`endif
                resp_tag_o   <= tag_q;
                resp_valid_o <= 1'b1;
            end else if ((state_q == RESP) && resp_ready_i) begin
                resp_valid_o <= 1'b0;
            end
        end
    end

    assign req_ready_o = !full;
    assign mul_start_o = (state_q == ISSUE);
    assign busy_o      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_mul_dispatch.sv
// Scoreboard bench for mul_dispatch with a behavioural sequential-multiplier model.
module tb_mul_dispatch;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [7:0]  req_a, req_b;
    logic [3:0]  req_tag;
    logic [7:0]  mul_a, mul_b;
    logic        mul_start, mul_busy;
    logic [15:0] mul_y;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_data;
    logic [3:0]  resp_tag;
    logic        busy;

    always #5 clk = ~clk;

    mul_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_tag_i    (req_tag),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_start_o  (mul_start),
        .mul_busy_i   (mul_busy),
        .mul_y_i      (mul_y),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_tag_o   (resp_tag),
        .busy_o       (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int start_cnt = 0;
    logic [19:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Unsigned core: samples start, busy for 9 cycles, product valid once busy drops
    int          mcnt;
    logic [7:0]  ma, mb;
    always @(posedge clk) begin
        if (!rst_n) begin
            mul_busy <= 1'b0;
            mcnt     <= 0;
            mul_y    <= '0;
        end else if (mul_busy) begin
            if (mcnt == 0) begin
                mul_busy <= 1'b0;
                mul_y    <= {8'h00, ma} * {8'h00, mb};
            end else begin
                mcnt <= mcnt - 1;
            end
        end else if (mul_start) begin
            mul_busy <= 1'b1;
            mcnt     <= 8;
            ma       <= mul_a;
            mb       <= mul_b;
            mul_y    <= 16'($urandom);
        end
    end

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
`ifdef MUL_DISPATCH_SIGNED_EN
        p = int'($signed(a)) * int'($signed(b));
`else
        p = int'(a) * int'(b);
`endif
        return p[15:0];
    endfunction

    // Monitor: scoreboard pop on handshake, plus protocol checks
    logic        prev_start = 1'b0;
    logic        held_v = 1'b0;
    logic [15:0] held_d;
    logic [3:0]  held_t;
    always @(negedge clk) begin
        logic [19:0] e;
        if (rst_n) begin
            if (mul_start) begin
                chk("start_while_busy", {31'd0, mul_busy}, 0);
                chk("start_during_resp", {31'd0, resp_valid}, 0);
                chk("start_one_cycle", {31'd0, prev_start}, 0);
                start_cnt++;
            end
            if (resp_valid && held_v) begin
                chk("resp_hold_data", {16'd0, resp_data}, {16'd0, held_d});
                chk("resp_hold_tag", {28'd0, resp_tag}, {28'd0, held_t});
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", {16'd0, resp_data}, {16'd0, e[15:0]});
                    chk("resp_tag", {28'd0, resp_tag}, {28'd0, e[19:16]});
                end
            end
            held_v     = resp_valid && !resp_ready;
            held_d     = resp_data;
            held_t     = resp_tag;
            prev_start = mul_start;
        end else begin
            held_v     = 1'b0;
            prev_start = 1'b0;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
        int n = 0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = t;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) chk("req_accept_timeout", 0, 1);
        else exp_q.push_back({t, ref_mul(a, b)});
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int n = 0;
        @(negedge clk);
        while (!resp_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_mul_a", {24'd0, mul_a}, 0);
        chk("rst_mul_b", {24'd0, mul_b}, 0);
        chk("rst_start", {31'd0, mul_start}, 0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 0);
        chk("rst_resp_data", {16'd0, resp_data}, 0);
        chk("rst_resp_tag", {28'd0, resp_tag}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
    endtask

    // Single operation from idle: product, tag, 12-cycle latency, one start pulse
    task automatic op_check(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                            input logic [15:0] expd);
        int s;
        s = start_cnt;
        resp_ready = 1'b1;
        send(a, b, t);
        wait_resp();
        chk("dir_latency", cyc - acc_cyc, 12);
        chk("dir_data", {16'd0, resp_data}, {16'd0, expd});
        chk("dir_tag", {28'd0, resp_tag}, {28'd0, t});
        drain();
        chk("dir_start_count", start_cnt - s, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        logic snd_done;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        op_check(8'd13, 8'd11, 4'd3, 16'd143);
`ifdef MUL_DISPATCH_SIGNED_EN
        op_check(8'hFD, 8'd7,  4'd1, 16'hFFEB);
        op_check(8'h80, 8'h80, 4'd2, 16'h4000);
        op_check(8'h00, 8'hFB, 4'd4, 16'h0000);
`else
        op_check(8'hFD, 8'd7,  4'd1, 16'h06EB);
        op_check(8'hFF, 8'hFF, 4'd2, 16'hFE01);
`endif

        // Fill the FIFO behind a busy FSM; the fifth queued request must stall
        send(8'd1, 8'd2, 4'd1);
        repeat (2) @(posedge clk);
        #1;
        send(8'd255, 8'd255, 4'd2);
        send(8'd200, 8'd3,   4'd4);
        send(8'd17,  8'd17,  4'd5);
        send(8'd0,   8'd99,  4'd6);
        @(negedge clk);
        chk("fifo_full_ready", {31'd0, req_ready}, 0);
        chk("fifo_full_busy", {31'd0, busy}, 1);
        @(posedge clk);
        #1;
        send(8'd128, 8'd2, 4'd7);
        drain();

        // Back-pressure on the response with another request queued
        resp_ready = 1'b0;
        send(8'hFD, 8'd7, 4'd8);
        send(8'd5,  8'd6, 4'd9);
        wait_resp();
        s = start_cnt;
        repeat (20) @(negedge clk);
        chk("hold_no_start", start_cnt - s, 0);
        chk("hold_valid", {31'd0, resp_valid}, 1);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain();

        // Reset in WAIT_LO with two requests queued
        send(8'd9, 8'd9, 4'd10);
        send(8'd3, 8'd4, 4'd11);
        send(8'd7, 8'd8, 4'd12);
        begin
            int n = 0;
            while (!mul_busy && n < 50) begin
                n++;
                @(negedge clk);
            end
            chk("mid_reset_busy_seen", {31'd0, mul_busy}, 1);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_reset_busy", {31'd0, busy}, 0);
        chk("post_reset_ready", {31'd0, req_ready}, 1);
        @(posedge clk);
        #1;

        // Randomised traffic with random response back-pressure
        snd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(8'($urandom), 8'($urandom), 4'($urandom));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                snd_done = 1'b1;
            end
            begin
                int k = 0;
                while ((!snd_done || exp_q.size() != 0) && k < 5000) begin
                    @(posedge clk);
                    #1;
                    resp_ready = 1'($urandom_range(0, 1));
                    k++;
                end
                resp_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
